commit_queue: RTL and testbench

- In-order instruction queue directly upstream of the commit stage.
- Accepts issued scoreboard entries and allocates each a transaction ID.
- Collects functional-unit writebacks (result and exception) by transaction ID.
- Presents the oldest NR_COMMIT_PORTS entries to the commit stage and retires them on commit_ack.

---
 rtl/commit_queue.sv | 198 +++++++++++++++++++
 tb/tb_commit_queue.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_queue.sv
// In-order commit queue sitting in front of the commit stage. Entries get a
// transaction ID on issue, collect writebacks by ID, and retire from the head.
// Optional macro COMMIT_QUEUE_WB_BYPASS_EN forwards same-cycle writebacks that
// target head entries straight onto commit_instr_o.

package ariane_pkg;
   localparam int unsigned TRANS_ID_BITS = 3;
   localparam int unsigned XLEN          = 64;

   typedef struct packed {
      logic [XLEN-1:0] cause;
      logic [XLEN-1:0] tval;
      logic            valid;
   } exception_t;

   typedef struct packed {
      logic [XLEN-1:0]          pc;
      logic [TRANS_ID_BITS-1:0] trans_id;
      logic [3:0]               fu;
      logic [6:0]               op;
      logic [4:0]               rs1;
      logic [4:0]               rs2;
      logic [4:0]               rd;
      logic [XLEN-1:0]          result;
      logic                     valid;
      exception_t               ex;
   } scoreboard_entry_t;
endpackage

module commit_queue
   import ariane_pkg::*;
#(
   parameter int unsigned NR_ENTRIES      = 8,
   parameter int unsigned NR_COMMIT_PORTS = 2,
   parameter int unsigned NR_WB_PORTS     = 4
) (
   input  logic                                          clk_i,
   input  logic                                          rst_ni,
   input  logic                                          flush_i,
   input  logic                                          issue_valid_i,
   input  scoreboard_entry_t                             issue_instr_i,
   output logic                                          issue_ack_o,
   output logic [TRANS_ID_BITS-1:0]                      issue_trans_id_o,
   input  logic [NR_WB_PORTS-1:0]                        wb_valid_i,
   input  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]     wb_trans_id_i,
   input  logic [NR_WB_PORTS-1:0][XLEN-1:0]              wb_data_i,
   input  exception_t [NR_WB_PORTS-1:0]                  wb_ex_i,
   output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]       commit_instr_o,
   input  logic [NR_COMMIT_PORTS-1:0]                    commit_ack_i,
   output logic [$clog2(NR_ENTRIES):0]                   occupancy_o
);

   localparam int unsigned PtrW = $clog2(NR_ENTRIES);
   typedef logic [PtrW-1:0] ptr_t;
   typedef logic [PtrW:0]   cnt_t;

   scoreboard_entry_t          mem_q [NR_ENTRIES];
   scoreboard_entry_t          mem_d [NR_ENTRIES];
   logic [NR_ENTRIES-1:0]      busy_q, busy_d, done_q, done_d;
   ptr_t                       issue_ptr_q, issue_ptr_d, commit_ptr_q, commit_ptr_d;
   cnt_t                       count_q, count_d;
   ptr_t                       head_idx [NR_COMMIT_PORTS];
   logic [NR_COMMIT_PORTS-1:0] retire;
   logic                       retire_chain;
   cnt_t                       n_retire;

   // Registered count gates issue, so a full queue never sees a same-cycle slot.
   assign issue_ack_o      = issue_valid_i && (count_q < cnt_t'(NR_ENTRIES)) && !flush_i;
   assign issue_trans_id_o = issue_ptr_q;
   assign occupancy_o      = count_q;

   // Slot index of each presented head entry.
   always_comb begin
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         head_idx[k] = commit_ptr_q + ptr_t'(k);
      end
   end

   // Present the oldest entries; valid only when occupied and finished.
   always_comb begin
      commit_instr_o = '0;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         commit_instr_o[k]       = mem_q[head_idx[k]];
         commit_instr_o[k].valid = busy_q[head_idx[k]] && done_q[head_idx[k]] &&
                                   (cnt_t'(k) < count_q);
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
         if (busy_q[head_idx[k]] && (cnt_t'(k) < count_q)) begin
            // Ascending scan so the highest-numbered port wins.
            for (int p = 0; p < NR_WB_PORTS; p++) begin
               if (wb_valid_i[p] && (wb_trans_id_i[p] == head_idx[k])) begin
                  commit_instr_o[k].result = wb_data_i[p];
                  commit_instr_o[k].valid  = 1'b1;
                  if (wb_ex_i[p].valid) commit_instr_o[k].ex = wb_ex_i[p];
               end
            end
         end
`endif
      end
   end

   // Retire a contiguous run of acked, valid heads starting at port 0.
   always_comb begin
      retire       = '0;
      n_retire     = '0;
      retire_chain = 1'b1;
      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         if (retire_chain && commit_ack_i[k] && commit_instr_o[k].valid) begin
            retire[k] = 1'b1;
            n_retire  = n_retire + cnt_t'(1);
         end else begin
            retire_chain = 1'b0;
         end
      end
   end

   // Next state: writeback, then issue, then retire; flush overrides everything.
   always_comb begin
      mem_d        = mem_q;
      busy_d       = busy_q;
      done_d       = done_q;
      issue_ptr_d  = issue_ptr_q;
      commit_ptr_d = commit_ptr_q;
      count_d      = count_q;

      for (int p = 0; p < NR_WB_PORTS; p++) begin
         if (wb_valid_i[p] && busy_q[wb_trans_id_i[p]]) begin
            mem_d[wb_trans_id_i[p]].result = wb_data_i[p];
            done_d[wb_trans_id_i[p]]       = 1'b1;
            if (wb_ex_i[p].valid) mem_d[wb_trans_id_i[p]].ex = wb_ex_i[p];
         end
      end

      if (issue_ack_o) begin
         mem_d[issue_ptr_q]          = issue_instr_i;
         mem_d[issue_ptr_q].valid    = 1'b0;
         mem_d[issue_ptr_q].trans_id = issue_ptr_q;
         busy_d[issue_ptr_q]         = 1'b1;
         done_d[issue_ptr_q]         = 1'b0;
         issue_ptr_d                 = issue_ptr_q + ptr_t'(1);
      end

      for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
         if (retire[k]) begin
            busy_d[head_idx[k]] = 1'b0;
            done_d[head_idx[k]] = 1'b0;
         end
      end
      commit_ptr_d = commit_ptr_q + ptr_t'(n_retire);
      count_d      = count_q + cnt_t'(issue_ack_o) - n_retire;

      if (flush_i) begin
         busy_d       = '0;
         done_d       = '0;
         issue_ptr_d  = '0;
         commit_ptr_d = '0;
         count_d      = '0;
      end
   end

   // Control state with asynchronous reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_q       <= '0;
         done_q       <= '0;
         issue_ptr_q  <= '0;
         commit_ptr_q <= '0;
         count_q      <= '0;
      end else begin
         busy_q       <= busy_d;
         done_q       <= done_d;
         issue_ptr_q  <= issue_ptr_d;
         commit_ptr_q <= commit_ptr_d;
         count_q      <= count_d;
      end
   end

   // Payload storage; contents are meaningless while busy is clear.
   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

`ifndef SYNTHESIS
   // Flag acks that the retire logic silently drops.
   always_ff @(posedge clk_i) begin
      if (rst_ni && !flush_i) begin
         for (int k = 1; k < NR_COMMIT_PORTS; k++) begin
            assert (!(commit_ack_i[k] && !commit_ack_i[k-1]))
               else $warning("commit_ack[%0d] without commit_ack[%0d] ignored", k, k - 1);
         end
         for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
            assert (!(commit_ack_i[k] && !commit_instr_o[k].valid))
               else $warning("commit_ack[%0d] on a non-valid entry ignored", k);
         end
      end
   end
`endif

endmodule

// File: tb/tb_commit_queue.sv
// Randomized scoreboard bench for commit_queue. The driver predicts each
// cycle's outputs from an in-order list model and queues them; a monitor pops
// and compares mid-cycle.
module tb_commit_queue;
   import ariane_pkg::*;

   localparam int unsigned NE = 8;
   localparam int unsigned NC = 2;
   localparam int unsigned NW = 4;

   logic                          clk, rst_n, flush;
   logic                          issue_valid, issue_ack;
   scoreboard_entry_t             issue_instr;
   logic [2:0]                    issue_trans_id;
   logic [NW-1:0]                 wb_valid;
   logic [NW-1:0][2:0]            wb_trans_id;
   logic [NW-1:0][63:0]           wb_data;
   exception_t [NW-1:0]           wb_ex;
   scoreboard_entry_t [NC-1:0]    commit_instr;
   logic [NC-1:0]                 commit_ack;
   logic [3:0]                    occupancy;

   commit_queue #(.NR_ENTRIES(NE), .NR_COMMIT_PORTS(NC), .NR_WB_PORTS(NW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .issue_valid_i(issue_valid), .issue_instr_i(issue_instr), .issue_ack_o(issue_ack),
      .issue_trans_id_o(issue_trans_id),
      .wb_valid_i(wb_valid), .wb_trans_id_i(wb_trans_id), .wb_data_i(wb_data),
      .wb_ex_i(wb_ex), .commit_instr_o(commit_instr), .commit_ack_i(commit_ack),
      .occupancy_o(occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: ordered list of live IDs plus per-ID contents.
   int          mq[$];
   bit          m_busy [NE];
   bit          m_done [NE];
   logic [63:0] m_pc   [NE];
   logic [63:0] m_res  [NE];
   exception_t  m_ex   [NE];
   int          m_iptr;

   typedef struct packed {
      logic                iack;
      logic [2:0]          tid;
      logic [3:0]          occ;
      logic [NC-1:0]       v;
      logic [NC-1:0][2:0]  id;
      logic [NC-1:0][63:0] pc;
      logic [NC-1:0][63:0] res;
      logic [NC-1:0]       exv;
      logic [NC-1:0][63:0] cause;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      for (int i = 0; i < NE; i++) begin
         m_busy[i] = 0;
         m_done[i] = 0;
      end
      m_iptr = 0;
   endfunction

   // Expected view of head position k given model state and current inputs.
   function automatic void predict(input int k, output bit v, output logic [2:0] id,
                                   output logic [63:0] pc, output logic [63:0] res,
                                   output bit exv, output logic [63:0] cause);
      v = 0; id = '0; pc = '0; res = '0; exv = 0; cause = '0;
      if (k < mq.size()) begin
         int i;
         i     = mq[k];
         id    = 3'(i);
         pc    = m_pc[i];
         res   = m_res[i];
         exv   = m_ex[i].valid;
         cause = m_ex[i].cause;
         v     = m_done[i];
`ifdef COMMIT_QUEUE_WB_BYPASS_EN
         for (int p = 0; p < NW; p++) begin
            if (wb_valid[p] && int'(wb_trans_id[p]) == i) begin
               res = wb_data[p];
               v   = 1;
               if (wb_ex[p].valid) begin
                  exv   = 1;
                  cause = wb_ex[p].cause;
               end
            end
         end
`endif
      end
   endfunction

   task automatic idle();
      issue_valid = 0;
      issue_instr = '0;
      wb_valid    = '0;
      wb_trans_id = '0;
      wb_data     = '0;
      wb_ex       = '0;
      commit_ack  = '0;
      flush       = 0;
   endtask

   task automatic new_instr();
      issue_valid          = 1;
      issue_instr          = '0;
      issue_instr.pc       = {$urandom, $urandom};
      issue_instr.result   = {$urandom, $urandom};
      issue_instr.trans_id = 3'($urandom);
      issue_instr.valid    = 1;
   endtask

   task automatic set_wb(input int p, input int id, input logic [63:0] data, input bit exv);
      wb_valid[p]       = 1;
      wb_trans_id[p]    = 3'(id);
      wb_data[p]        = data;
      wb_ex[p]          = '0;
      wb_ex[p].valid    = exv;
      wb_ex[p].cause    = exv ? {32'h0, $urandom} : 64'h0;
   endtask

   // Ack up to maxn valid heads in order, each with probability pct%.
   task automatic auto_ack(input int maxn, input int pct);
      bit ok, v, exv;
      logic [2:0] id;
      logic [63:0] pc, res, cause;
      ok = 1;
      commit_ack = '0;
      for (int k = 0; k < NC; k++) begin
         predict(k, v, id, pc, res, exv, cause);
         if (ok && k < maxn && v && $urandom_range(99) < pct) commit_ack[k] = 1;
         else ok = 0;
      end
   endtask

   // One clock: queue the expectation, let the edge happen, advance the model.
   task automatic cycle();
      exp_t e;
      bit v, exv, ok;
      logic [2:0] id;
      logic [63:0] pc, res, cause;
      int nret;
      e      = '0;
      e.iack = issue_valid && !flush && (mq.size() < NE);
      e.tid  = 3'(m_iptr);
      e.occ  = 4'(mq.size());
      for (int k = 0; k < NC; k++) begin
         predict(k, v, id, pc, res, exv, cause);
         e.v[k] = v; e.id[k] = id; e.pc[k] = pc; e.res[k] = res;
         e.exv[k] = exv; e.cause[k] = cause;
      end
      exp_q.push_back(e);
      nret = 0;
      ok   = 1;
      for (int k = 0; k < NC; k++) begin
         if (ok && commit_ack[k] && e.v[k]) nret++;
         else ok = 0;
      end
      @(posedge clk);
      if (flush) begin
         model_reset();
      end else begin
         for (int p = 0; p < NW; p++) begin
            if (wb_valid[p] && m_busy[wb_trans_id[p]]) begin
               m_res[wb_trans_id[p]]  = wb_data[p];
               m_done[wb_trans_id[p]] = 1;
               if (wb_ex[p].valid) m_ex[wb_trans_id[p]] = wb_ex[p];
            end
         end
         if (e.iack) begin
            m_pc[m_iptr]   = issue_instr.pc;
            m_res[m_iptr]  = issue_instr.result;
            m_ex[m_iptr]   = issue_instr.ex;
            m_busy[m_iptr] = 1;
            m_done[m_iptr] = 0;
            mq.push_back(m_iptr);
            m_iptr = (m_iptr + 1) % NE;
         end
         repeat (nret) begin
            int i;
            i = mq.pop_front();
            m_busy[i] = 0;
            m_done[i] = 0;
         end
      end
      #1;
   endtask

   // Pull reset low mid-cycle with traffic on the inputs; hold over one edge.
   task automatic async_reset();
      exp_t e;
      new_instr();
      if (mq.size() > 0) set_wb(0, mq[0], 64'h1234, 0);
      flush = 0;
      #2;
      rst_n = 0;
      model_reset();
      e      = '0;
      e.iack = 1;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      rst_n = 1;
      idle();
   endtask

   task automatic drain();
      for (int c = 0; c < 40 && mq.size() > 0; c++) begin
         idle();
         for (int k = 0; k < NC && k < mq.size(); k++) begin
            if (!m_done[mq[k]]) set_wb(k, mq[k], {$urandom, $urandom}, 0);
         end
         auto_ack(NC, 100);
         cycle();
      end
   endtask

   // Monitor: compare DUT outputs mid-cycle against queued expectations.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("issue_ack", 64'(issue_ack), 64'(e.iack));
            chk("issue_trans_id", 64'(issue_trans_id), 64'(e.tid));
            chk("occupancy", 64'(occupancy), 64'(e.occ));
            for (int k = 0; k < NC; k++) begin
               chk($sformatf("valid[%0d]", k), 64'(commit_instr[k].valid), 64'(e.v[k]));
               if (e.v[k]) begin
                  chk($sformatf("trans_id[%0d]", k), 64'(commit_instr[k].trans_id), 64'(e.id[k]));
                  chk($sformatf("pc[%0d]", k), commit_instr[k].pc, e.pc[k]);
                  chk($sformatf("result[%0d]", k), commit_instr[k].result, e.res[k]);
                  chk($sformatf("ex_valid[%0d]", k), 64'(commit_instr[k].ex.valid), 64'(e.exv[k]));
                  if (e.exv[k]) chk($sformatf("ex_cause[%0d]", k), commit_instr[k].ex.cause, e.cause[k]);
               end
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0;
      idle();
      model_reset();
      @(posedge clk);
      #1;
      async_reset();

      // In-order commit with out-of-order writebacks.
      repeat (3) begin idle(); new_instr(); cycle(); end
      idle(); set_wb(0, 1, 64'h11, 0); auto_ack(1, 100); cycle();
      idle(); set_wb(0, 0, 64'h10, 1); auto_ack(1, 100); cycle();
      idle(); set_wb(0, 2, 64'h12, 0); auto_ack(1, 100); cycle();
      repeat (4) begin idle(); auto_ack(1, 100); cycle(); end

      // Fill, reject when full, retire-two with rejected issue, then wrap to ID 0.
      idle(); flush = 1; cycle();
      repeat (9) begin idle(); new_instr(); cycle(); end
      idle(); set_wb(0, 0, 64'hA0, 0); set_wb(1, 1, 64'hA1, 0); cycle();
      idle(); new_instr(); commit_ack = 2'b11; cycle();
      idle(); new_instr(); cycle();
      idle(); cycle();

      // Port priority on one ID; writeback to an empty slot is dropped.
      idle(); set_wb(0, 5, 64'hA, 0); set_wb(3, 5, 64'hB, 0); set_wb(1, 1, 64'h55, 0); cycle();
      idle(); new_instr(); cycle();
      idle(); cycle();
      drain();

      // Out-of-order ack is ignored; a paired ack retires two.
      idle(); flush = 1; cycle();
      repeat (2) begin idle(); new_instr(); cycle(); end
      idle(); set_wb(0, 0, 64'hC0, 0); set_wb(2, 1, 64'hC1, 1); cycle();
      idle(); commit_ack = 2'b10; cycle();
      idle(); commit_ack = 2'b11; cycle();
      idle(); cycle();

      // Flush dominates a same-cycle issue and writeback.
      repeat (5) begin idle(); new_instr(); cycle(); end
      idle(); new_instr(); set_wb(0, mq[0], 64'hD0, 0); flush = 1; cycle();
      idle(); new_instr(); cycle();
      repeat (4) begin idle(); new_instr(); cycle(); end
      idle(); set_wb(1, mq[0], 64'hE0, 0); cycle();
      idle();
      async_reset();
      idle(); new_instr(); cycle();
      idle(); cycle();

      // Writeback-to-head visibility timing.
      idle(); flush = 1; cycle();
      idle(); new_instr(); cycle();
      idle(); set_wb(2, 0, 64'hF0, 0); cycle();
      idle(); cycle();
      idle(); auto_ack(1, 100); cycle();

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         idle();
         if ($urandom_range(99) < 70) new_instr();
         for (int p = 0; p < NW; p++) begin
            if ($urandom_range(99) < 35) begin
               int id;
               if (mq.size() > 0 && $urandom_range(9) < 8) id = mq[$urandom_range(mq.size() - 1)];
               else id = $urandom_range(NE - 1);
               set_wb(p, id, {$urandom, $urandom}, $urandom_range(9) == 0);
            end
         end
         auto_ack(NC, 80);
         if ($urandom_range(199) == 0) flush = 1;
         if ($urandom_range(699) == 0) async_reset();
         else cycle();
      end
      drain();
      idle(); cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
